// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage feeding the MEM/WB buffer.
// It holds the data memory (two half-word lanes, synchronous access) and
// registers the result word, low byte and forwarding tag one cycle after
// acceptance. It also handles stall, flush and misalignment detection.
module mem_access_stage #(
    parameter int S  = 15,  // MSB index of the data word
    parameter int AW = 8,   // byte-address width
    parameter int FW = 15   // MSB index of the forwarding tag
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InValid,
    input  logic [2:0]    InOp,
    input  logic [AW-1:0] InAddr,
    input  logic [S:0]    InAlu,
    input  logic [S:0]    InStore,
    input  logic [FW:0]   ForwardIn,
    input  logic          Stall,
    input  logic          Flush,
    output logic          OutValid,
    output logic [S:0]    OutWord,
    output logic [7:0]    OutByte,
    output logic [FW:0]   ForwardOut,
    output logic          MisalignErr
);

    localparam int DEPTH = 2 ** (AW - 1);
    localparam int HW    = (S + 1) / 2;   // width of one byte lane (half word)

    localparam logic [2:0] OP_LW = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b011;
    localparam logic [2:0] OP_SB = 3'b100;

    // Where the registered output word comes from.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_WORD = 2'd1,
        SRC_BYTE = 2'd2
    } src_e;

    logic          accept;
    logic [AW-2:0] widx;
    logic          bsel;
    logic          sb_op;
    logic [1:0]    lane_we;
    logic          rd_en;
    src_e          src_next;
    logic          mis_next;

    src_e          src_reg;
    logic          valid_reg;
    logic          bsel_reg;
    logic [S:0]    alu_reg;
    logic [FW:0]   fwd_reg;
    logic          mis_reg;

    logic [S:0]    rd_word;
    logic [7:0]    rd_byte;

    assign accept = InValid & ~Stall & ~Flush & ~rst;
    assign widx   = InAddr[AW-1:1];
    assign bsel   = InAddr[0];
    assign sb_op  = (InOp == OP_SB);

    // Decode the op into lane write enables, read enable and output source.
    // Everything is gated by accept so stalls, flushes and reset never touch memory.
    always_comb begin
        lane_we  = 2'b00;
        rd_en    = 1'b0;
        src_next = SRC_ALU;
        mis_next = 1'b0;
        if (accept) begin
            case (InOp)
                OP_LW: begin
                    if (bsel) begin
                        mis_next = 1'b1;
                    end else begin
                        rd_en    = 1'b1;
                        src_next = SRC_WORD;
                    end
                end
                OP_LB: begin
                    rd_en    = 1'b1;
                    src_next = SRC_BYTE;
                end
                OP_SW: begin
                    if (bsel) begin
                        mis_next = 1'b1;
                    end else begin
                        lane_we = 2'b11;
                    end
                end
                OP_SB: begin
                    lane_we[bsel] = 1'b1;
                end
                default: begin
                    // NOP and unused codes just pass the ALU result through
                end
            endcase
        end
    end

    // One RAM per byte lane so a byte store needs no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [HW-1:0] mem_lane [0:DEPTH-1];
            logic [HW-1:0] wdata;
            logic [HW-1:0] rd_lane_reg;

            assign wdata = sb_op ? HW'(InStore[7:0]) : InStore[gi*HW +: HW];

            // Synchronous write and registered read; the read register only
            // loads on an accepted load, so it naturally holds during stalls.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem_lane[widx] <= wdata;
                end
                if (rd_en) begin
                    rd_lane_reg <= mem_lane[widx];
                end
            end
        end
    endgenerate

    // Pipeline register for the non-memory part of the result; bubbles clear
    // tag and ALU value so nothing stale is ever forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            src_reg   <= SRC_ALU;
            bsel_reg  <= 1'b0;
            alu_reg   <= '0;
            fwd_reg   <= '0;
            mis_reg   <= 1'b0;
        end else if (!Stall) begin
            if (accept) begin
                valid_reg <= 1'b1;
                src_reg   <= src_next;
                bsel_reg  <= bsel;
                alu_reg   <= InAlu;
                fwd_reg   <= ForwardIn;
                mis_reg   <= mis_next;
            end else begin
                valid_reg <= 1'b0;
                src_reg   <= SRC_ALU;
                bsel_reg  <= 1'b0;
                alu_reg   <= '0;
                fwd_reg   <= '0;
                mis_reg   <= 1'b0;
            end
        end
    end

    // Select the final word from registered state only (no input-to-output path).
    always_comb begin
        rd_word = {g_lane[1].rd_lane_reg, g_lane[0].rd_lane_reg};
        rd_byte = bsel_reg ? g_lane[1].rd_lane_reg[7:0] : g_lane[0].rd_lane_reg[7:0];
        case (src_reg)
            SRC_WORD: OutWord = rd_word;
            SRC_BYTE: OutWord = {{(S - 7){1'b0}}, rd_byte};
            default:  OutWord = alu_reg;
        endcase
    end

    assign OutByte     = OutWord[7:0];
    assign OutValid    = valid_reg;
    assign ForwardOut  = fwd_reg;
    assign MisalignErr = mis_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios with constant expectations
// followed by randomized traffic checked against a behavioural model.
module tb_mem_access_stage;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] LW  = 3'b001;
    localparam logic [2:0] LB  = 3'b010;
    localparam logic [2:0] SW  = 3'b011;
    localparam logic [2:0] SB  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic [2:0]  InOp;
    logic [7:0]  InAddr;
    logic [15:0] InAlu;
    logic [15:0] InStore;
    logic [15:0] ForwardIn;
    logic        Stall;
    logic        Flush;
    logic        OutValid;
    logic [15:0] OutWord;
    logic [7:0]  OutByte;
    logic [15:0] ForwardOut;
    logic        MisalignErr;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [15:0] mem_m [0:127];
    logic        exp_valid = 1'b0;
    logic [15:0] exp_word  = 16'h0;
    logic [15:0] exp_fwd   = 16'h0;
    logic        exp_mis   = 1'b0;

    mem_access_stage #(.S(15), .AW(8), .FW(15)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InOp(InOp), .InAddr(InAddr),
        .InAlu(InAlu), .InStore(InStore), .ForwardIn(ForwardIn), .Stall(Stall),
        .Flush(Flush), .OutValid(OutValid), .OutWord(OutWord), .OutByte(OutByte),
        .ForwardOut(ForwardOut), .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model at the edge, sample 1ns later.
    task automatic drive(input logic r, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [15:0] alu,
                         input logic [15:0] st, input logic [15:0] fw,
                         input logic stl, input logic fl);
        int idx;
        rst = r; InValid = v; InOp = op; InAddr = a; InAlu = alu;
        InStore = st; ForwardIn = fw; Stall = stl; Flush = fl;
        @(posedge clk);
        idx = int'(a) / 2;
        if (r) begin
            exp_valid = 0; exp_word = 0; exp_fwd = 0; exp_mis = 0;
        end else if (stl) begin
            // everything holds
        end else if (!v || fl) begin
            exp_valid = 0; exp_word = 0; exp_fwd = 0; exp_mis = 0;
        end else begin
            exp_valid = 1; exp_fwd = fw; exp_mis = 0; exp_word = alu;
            if (op == LW) begin
                if (a[0]) exp_mis = 1;
                else exp_word = mem_m[idx];
            end else if (op == LB) begin
                exp_word = (mem_m[idx] >> (a[0] ? 8 : 0)) & 16'h00FF;
            end else if (op == SW) begin
                if (a[0]) exp_mis = 1;
                else mem_m[idx] = st;
            end else if (op == SB) begin
                if (a[0]) mem_m[idx] = {st[7:0], mem_m[idx][7:0]};
                else mem_m[idx] = {mem_m[idx][15:8], st[7:0]};
            end
        end
        #1;
        $display("t=%0t rst=%0b v=%0b op=%0d a=%02h alu=%04h st=%04h fw=%04h stall=%0b flush=%0b -> ov=%0b w=%04h b=%02h fo=%04h mis=%0b",
                 $time, r, v, op, a, alu, st, fw, stl, fl, OutValid, OutWord, OutByte, ForwardOut, MisalignErr);
    endtask

    task automatic test_reset();
        drive(1, 0, NOP, 8'h00, 16'h0, 16'h0, 16'h0, 0, 0);
        drive(1, 0, NOP, 8'h00, 16'h0, 16'h0, 16'h0, 0, 0);
        checks++;
        if (OutValid !== 1'b0 || OutWord !== 16'h0 || OutByte !== 8'h0 || ForwardOut !== 16'h0 || MisalignErr !== 1'b0)
            $display("FAIL reset_init: got v=%0b w=%h b=%h f=%h m=%0b want all 0", OutValid, OutWord, OutByte, ForwardOut, MisalignErr);
        else passed++;
        drive(0, 1, SW, 8'h04, 16'h0004, 16'h1111, 16'h0001, 0, 0);
        checks++;
        if (OutValid !== 1'b1 || OutWord !== 16'h0004)
            $display("FAIL reset_presw: got v=%0b w=%h want v=1 w=0004", OutValid, OutWord);
        else passed++;
        // reset with stall asserted still clears, and suppresses the store
        drive(1, 1, SW, 8'h04, 16'h0004, 16'hBEEF, 16'h0002, 1, 0);
        checks++;
        if (OutValid !== 1'b0 || OutWord !== 16'h0 || ForwardOut !== 16'h0 || MisalignErr !== 1'b0)
            $display("FAIL reset_stall: got v=%0b w=%h f=%h m=%0b want all 0", OutValid, OutWord, ForwardOut, MisalignErr);
        else passed++;
        drive(1, 1, SW, 8'h04, 16'h0004, 16'hBEEF, 16'h0002, 0, 0);
        checks++;
        if (OutValid !== 1'b0 || OutWord !== 16'h0 || ForwardOut !== 16'h0)
            $display("FAIL reset_hold: got v=%0b w=%h f=%h want all 0", OutValid, OutWord, ForwardOut);
        else passed++;
        drive(0, 1, LW, 8'h04, 16'h0ABC, 16'h0, 16'h0042, 0, 0);
        checks++;
        if (OutWord !== 16'h1111 || OutValid !== 1'b1 || ForwardOut !== 16'h0042)
            $display("FAIL reset_nowrite: got w=%h v=%0b f=%h want w=1111 v=1 f=0042", OutWord, OutValid, ForwardOut);
        else passed++;
    endtask

    task automatic test_store_load();
        drive(0, 1, SW, 8'h10, 16'h0010, 16'h1234, 16'h0001, 0, 0);
        drive(0, 1, LW, 8'h10, 16'h0010, 16'h0000, 16'h0005, 0, 0);
        checks++;
        if (OutWord !== 16'h1234 || OutByte !== 8'h34)
            $display("FAIL sl_data: got w=%h b=%h want w=1234 b=34", OutWord, OutByte);
        else passed++;
        checks++;
        if (OutValid !== 1'b1 || ForwardOut !== 16'h0005 || MisalignErr !== 1'b0)
            $display("FAIL sl_ctrl: got v=%0b f=%h m=%0b want v=1 f=0005 m=0", OutValid, ForwardOut, MisalignErr);
        else passed++;
    endtask

    task automatic test_byte_ops();
        drive(0, 1, SB, 8'h11, 16'h0011, 16'h00AB, 16'h0002, 0, 0);
        checks++;
        if (OutWord !== 16'h0011 || OutValid !== 1'b1)
            $display("FAIL sb_out: got w=%h v=%0b want w=0011 v=1", OutWord, OutValid);
        else passed++;
        drive(0, 1, LW, 8'h10, 16'h0, 16'h0, 16'h0003, 0, 0);
        checks++;
        if (OutWord !== 16'hAB34)
            $display("FAIL sb_lane: got w=%h want AB34", OutWord);
        else passed++;
        drive(0, 1, LB, 8'h11, 16'h0, 16'h0, 16'h0004, 0, 0);
        checks++;
        if (OutWord !== 16'h00AB || OutByte !== 8'hAB)
            $display("FAIL lb_hi: got w=%h b=%h want w=00AB b=AB", OutWord, OutByte);
        else passed++;
        drive(0, 1, LB, 8'h10, 16'hFFFF, 16'h0, 16'h0004, 0, 0);
        checks++;
        if (OutWord !== 16'h0034 || OutByte !== 8'h34)
            $display("FAIL lb_lo: got w=%h b=%h want w=0034 b=34", OutWord, OutByte);
        else passed++;
    endtask

    task automatic test_misalign();
        drive(0, 1, SW, 8'h20, 16'h0020, 16'h5555, 16'h0008, 0, 0);
        drive(0, 1, SW, 8'h21, 16'h0021, 16'hFFFF, 16'h0009, 0, 0);
        checks++;
        if (OutWord !== 16'h0021 || MisalignErr !== 1'b1 || OutValid !== 1'b1 || ForwardOut !== 16'h0009 || OutByte !== 8'h21)
            $display("FAIL mis_sw: got w=%h m=%0b v=%0b f=%h b=%h want w=0021 m=1 v=1 f=0009 b=21", OutWord, MisalignErr, OutValid, ForwardOut, OutByte);
        else passed++;
        drive(0, 1, LW, 8'h20, 16'h0, 16'h0, 16'h000A, 0, 0);
        checks++;
        if (OutWord !== 16'h5555 || MisalignErr !== 1'b0)
            $display("FAIL mis_nowrite: got w=%h m=%0b want w=5555 m=0", OutWord, MisalignErr);
        else passed++;
        drive(0, 1, LW, 8'h21, 16'h1234, 16'h0, 16'h000B, 0, 0);
        checks++;
        if (OutWord !== 16'h1234 || MisalignErr !== 1'b1 || OutValid !== 1'b1)
            $display("FAIL mis_lw: got w=%h m=%0b v=%0b want w=1234 m=1 v=1", OutWord, MisalignErr, OutValid);
        else passed++;
        drive(0, 1, LB, 8'h21, 16'h1234, 16'h0, 16'h000C, 0, 0);
        checks++;
        if (OutWord !== 16'h0055 || MisalignErr !== 1'b0)
            $display("FAIL lb_odd: got w=%h m=%0b want w=0055 m=0", OutWord, MisalignErr);
        else passed++;
    endtask

    task automatic test_stall_flush();
        drive(0, 1, SW, 8'h30, 16'h0030, 16'h7777, 16'h0010, 0, 0);
        drive(0, 1, LW, 8'h10, 16'h0, 16'h0, 16'h0033, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, SW, 8'h10, 16'h0999, 16'h0000, 16'h0077, 1, (i == 1));
            checks++;
            if (OutWord !== 16'hAB34 || ForwardOut !== 16'h0033 || OutValid !== 1'b1)
                $display("FAIL stall_hold%0d: got w=%h f=%h v=%0b want w=AB34 f=0033 v=1", i, OutWord, ForwardOut, OutValid);
            else passed++;
        end
        drive(0, 1, SW, 8'h30, 16'h0030, 16'h9999, 16'h0044, 0, 1);
        checks++;
        if (OutValid !== 1'b0 || ForwardOut !== 16'h0 || OutWord !== 16'h0 || MisalignErr !== 1'b0)
            $display("FAIL flush: got v=%0b f=%h w=%h m=%0b want all 0", OutValid, ForwardOut, OutWord, MisalignErr);
        else passed++;
        drive(0, 1, LW, 8'h30, 16'h0, 16'h0, 16'h0045, 0, 0);
        checks++;
        if (OutWord !== 16'h7777)
            $display("FAIL flush_nowrite: got w=%h want 7777", OutWord);
        else passed++;
        drive(0, 1, LW, 8'h10, 16'h0, 16'h0, 16'h0046, 0, 0);
        checks++;
        if (OutWord !== 16'hAB34)
            $display("FAIL stall_nowrite: got w=%h want AB34", OutWord);
        else passed++;
        drive(0, 0, NOP, 8'h00, 16'h0001, 16'h0, 16'h0055, 0, 0);
        checks++;
        if (OutValid !== 1'b0 || ForwardOut !== 16'h0 || OutWord !== 16'h0)
            $display("FAIL invalid_bubble: got v=%0b f=%h w=%h want all 0", OutValid, ForwardOut, OutWord);
        else passed++;
    endtask

    task automatic test_passthrough();
        logic [2:0] ops [4];
        ops[0] = 3'b000; ops[1] = 3'b111; ops[2] = 3'b101; ops[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, ops[i], 8'h10 + 8'(i & 1), 16'h5A5A, 16'hDEAD, 16'h0007, 0, 0);
            checks++;
            if (OutWord !== 16'h5A5A || OutByte !== 8'h5A || ForwardOut !== 16'h0007 || OutValid !== 1'b1 || MisalignErr !== 1'b0)
                $display("FAIL pass_op%0d: got w=%h b=%h f=%h v=%0b m=%0b want w=5A5A b=5A f=0007 v=1 m=0",
                         ops[i], OutWord, OutByte, ForwardOut, OutValid, MisalignErr);
            else passed++;
        end
        drive(0, 1, LW, 8'h10, 16'h0, 16'h0, 16'h0008, 0, 0);
        checks++;
        if (OutWord !== 16'hAB34)
            $display("FAIL pass_nowrite: got w=%h want AB34", OutWord);
        else passed++;
    endtask

    task automatic test_random();
        // Fill every word so the model and RAM agree everywhere
        for (int i = 0; i < 128; i++)
            drive(0, 1, SW, 8'(i * 2), 16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic r, v, stl, fl;
            r   = ($urandom_range(0, 99) < 2);
            v   = ($urandom_range(0, 99) < 85);
            stl = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 10);
            drive(r, v, 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), stl, fl);
            checks++;
            if (OutValid !== exp_valid || OutWord !== exp_word || OutByte !== exp_word[7:0] ||
                ForwardOut !== exp_fwd || MisalignErr !== exp_mis)
                $display("FAIL rand%0d: got v=%0b w=%h b=%h f=%h m=%0b want v=%0b w=%h b=%h f=%h m=%0b",
                         n, OutValid, OutWord, OutByte, ForwardOut, MisalignErr,
                         exp_valid, exp_word, exp_word[7:0], exp_fwd, exp_mis);
            else passed++;
        end
        // Back-to-back store/load pairs across random words
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  a;
            logic [15:0] d;
            a = 8'($urandom) & 8'hFE;
            d = 16'($urandom);
            drive(0, 1, SW, a, 16'h0, d, 16'h0, 0, 0);
            drive(0, 1, LW, a, 16'h0, 16'h0, 16'(n), 0, 0);
            checks++;
            if (OutWord !== d || ForwardOut !== 16'(n) || OutValid !== 1'b1)
                $display("FAIL b2b%0d: got w=%h f=%h v=%0b want w=%h f=%h v=1", n, OutWord, ForwardOut, OutValid, d, 16'(n));
            else passed++;
        end
    endtask

    initial begin
        rst = 1; InValid = 0; InOp = 0; InAddr = 0; InAlu = 0; InStore = 0;
        ForwardIn = 0; Stall = 0; Flush = 0;
        test_reset();
        test_store_load();
        test_byte_ops();
        test_misalign();
        test_stall_flush();
        test_passthrough();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
